// File: rtl/uart_gpio_bridge_pkg.sv
// ---------------------------------------------------------------------------
// uart_gpio_bridge_pkg
// Shared definitions for the UART-to-GPIO command bridge:
//   - FSM state encoding (IDLE=0 .. RESP=5, also exported on state_dbg)
//   - command byte values ('0' read, '1' write, '2' direction)
//   - reply byte values ('0'/'1' read result, 'K' ok, 'E' range error)
//   - is_cmd(): recognises the three command opcodes
// ---------------------------------------------------------------------------
package uart_gpio_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_BANK = 3'd1,
    ST_GET_PIN  = 3'd2,
    ST_GET_VAL  = 3'd3,
    ST_EXEC     = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

  localparam logic [7:0] CMD_READ  = 8'h30;
  localparam logic [7:0] CMD_WRITE = 8'h31;
  localparam logic [7:0] CMD_DIR   = 8'h32;

  localparam logic [7:0] RPL_ZERO  = 8'h30;
  localparam logic [7:0] RPL_ONE   = 8'h31;
  localparam logic [7:0] RPL_OK    = 8'h4B;
  localparam logic [7:0] RPL_ERR   = 8'h45;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_READ) || (b == CMD_WRITE) || (b == CMD_DIR);
  endfunction

endpackage

// File: rtl/uart_gpio_bridge_gpio_sync.sv
// ---------------------------------------------------------------------------
// gpio_sync
// Two-flop synchroniser for asynchronous pad inputs, one chain per bit.
// Ports:
//   clk   in  1      system clock
//   nRst  in  1      asynchronous active-low reset (both stages clear to 0)
//   d     in  WIDTH  asynchronous inputs
//   q     out WIDTH  synchronised outputs (two clk cycles of latency)
// ---------------------------------------------------------------------------
module gpio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      meta_p0 <= '0;
      q       <= '0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/uart_gpio_bridge.sv
// ---------------------------------------------------------------------------
// uart_gpio_bridge
// Byte-level command parser between a UART byte interface and GPIO banks.
// Commands: '0' bank pin      -> reply '0'/'1' (synchronised pin input)
//           '1' bank pin val  -> gpio_out bit = val[0], reply 'K'
//           '2' bank pin val  -> gpio_oe  bit = val[0], reply 'K'
//           out-of-range bank/pin -> reply 'E', no GPIO change
// Optional feature: define UART_GPIO_TIMEOUT_EN to abort partial commands
// after TIMEOUT_CYCLES idle cycles between bytes (silently, no reply).
// Ports:
//   clk        in  1      system clock
//   nRst       in  1      asynchronous active-low reset
//   rx_valid   in  1      strobe: rx_data holds a received byte
//   rx_data    in  8      received byte
//   tx_ready   in  1      transmitter can accept a byte
//   tx_valid   out 1      reply valid, held until accepted
//   tx_data    out 8      reply byte
//   gpio_in    in  N*W    asynchronous pin inputs
//   gpio_out   out N*W    pin output values (bank b pin p at b*W+p)
//   gpio_oe    out N*W    pin output enables, 1 = drive
//   state_dbg  out 3      current FSM state
// ---------------------------------------------------------------------------
module uart_gpio_bridge
  import uart_gpio_bridge_pkg::*;
#(
  parameter int NUM_BANKS      = 4,
  parameter int BANK_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                            clk,
  input  logic                            nRst,
  input  logic                            rx_valid,
  input  logic [7:0]                      rx_data,
  input  logic                            tx_ready,
  output logic                            tx_valid,
  output logic [7:0]                      tx_data,
  input  logic [NUM_BANKS*BANK_WIDTH-1:0] gpio_in,
  output logic [NUM_BANKS*BANK_WIDTH-1:0] gpio_out,
  output logic [NUM_BANKS*BANK_WIDTH-1:0] gpio_oe,
  output logic [2:0]                      state_dbg
);

  localparam int TOT = NUM_BANKS * BANK_WIDTH;

  state_e           state;
  logic [7:0]       cmd_q;
  logic [7:0]       bank_q;
  logic [7:0]       pin_q;
  logic             val_q;
  logic [TOT-1:0]   gpio_sync_q;
  logic             in_range;
  logic [TOT-1:0]   sel;
  logic             rd_bit;
  logic             tmo_hit;
  int               idx;

  gpio_sync #(.WIDTH(TOT)) u_sync (
    .clk  (clk),
    .nRst (nRst),
    .d    (gpio_in),
    .q    (gpio_sync_q)
  );

  // One-hot select of the addressed pin; all-zero when out of range, so
  // the index is effectively only formed for legal bank/pin pairs.
  always_comb begin
    in_range = (int'(bank_q) < NUM_BANKS) && (int'(pin_q) < BANK_WIDTH);
    idx      = int'(bank_q) * BANK_WIDTH + int'(pin_q);
    sel      = '0;
    for (int i = 0; i < TOT; i++) begin
      sel[i] = in_range && (idx == i);
    end
    rd_bit   = |(gpio_sync_q & sel);
  end

`ifdef UART_GPIO_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [TW-1:0] tmo_cnt;
  logic          in_get;

  assign in_get  = (state == ST_GET_BANK) || (state == ST_GET_PIN) ||
                   (state == ST_GET_VAL);
  assign tmo_hit = in_get && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      tmo_cnt <= '0;
    end else if (rx_valid || !in_get) begin
      tmo_cnt <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= ST_IDLE;
      cmd_q    <= '0;
      bank_q   <= '0;
      pin_q    <= '0;
      val_q    <= 1'b0;
      gpio_out <= '0;
      gpio_oe  <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_valid && is_cmd(rx_data)) begin
            cmd_q <= rx_data;
            state <= ST_GET_BANK;
          end
        end
        ST_GET_BANK: begin
          if (rx_valid) begin
            bank_q <= rx_data;
            state  <= ST_GET_PIN;
          end else if (tmo_hit) begin
            state  <= ST_IDLE;
          end
        end
        ST_GET_PIN: begin
          if (rx_valid) begin
            pin_q <= rx_data;
            state <= (cmd_q == CMD_READ) ? ST_EXEC : ST_GET_VAL;
          end else if (tmo_hit) begin
            state <= ST_IDLE;
          end
        end
        ST_GET_VAL: begin
          if (rx_valid) begin
            val_q <= rx_data[0];
            state <= ST_EXEC;
          end else if (tmo_hit) begin
            state <= ST_IDLE;
          end
        end
        // Single execute cycle: GPIO update and reply load happen together,
        // so both become visible on the same edge.
        ST_EXEC: begin
          state    <= ST_RESP;
          tx_valid <= 1'b1;
          if (!in_range) begin
            tx_data <= RPL_ERR;
          end else if (cmd_q == CMD_READ) begin
            tx_data <= rd_bit ? RPL_ONE : RPL_ZERO;
          end else if (cmd_q == CMD_WRITE) begin
            gpio_out <= (gpio_out & ~sel) | (sel & {TOT{val_q}});
            tx_data  <= RPL_OK;
          end else begin
            gpio_oe  <= (gpio_oe & ~sel) | (sel & {TOT{val_q}});
            tx_data  <= RPL_OK;
          end
        end
        // Reply held until the transmitter takes it; incoming bytes dropped.
        ST_RESP: begin
          if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_uart_gpio_bridge.sv
module tb_uart_gpio_bridge;
  localparam int NB  = 4;
  localparam int BW  = 8;
  localparam int TOT = NB * BW;
  localparam int TMO = 100;

  logic           clk = 1'b0;
  logic           nRst = 1'b0;
  logic           rx_valid = 1'b0;
  logic [7:0]     rx_data = 8'h00;
  logic           tx_ready = 1'b0;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic [TOT-1:0] gpio_in = '0;
  logic [TOT-1:0] gpio_out;
  logic [TOT-1:0] gpio_oe;
  logic [2:0]     state_dbg;

  int errors = 0;
  int checks = 0;

  // Reference model: pin state per bank/pin.
  bit mo  [NB][BW];
  bit moe [NB][BW];

  uart_gpio_bridge #(
    .NUM_BANKS      (NB),
    .BANK_WIDTH     (BW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .nRst      (nRst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .gpio_oe   (gpio_oe),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish within 50000 cycles");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [TOT-1:0] flat(input bit want_oe);
    logic [TOT-1:0] r;
    r = '0;
    for (int b = 0; b < NB; b++)
      for (int p = 0; p < BW; p++)
        if (want_oe ? moe[b][p] : mo[b][p]) r = r | (TOT'(1) << (b * BW + p));
    return r;
  endfunction

  function automatic void model_reset();
    for (int b = 0; b < NB; b++)
      for (int p = 0; p < BW; p++) begin
        mo[b][p]  = 1'b0;
        moe[b][p] = 1'b0;
      end
  endfunction

  // Expected reply for a command, updating the model pin state.
  function automatic logic [7:0] model_cmd(input logic [7:0] c, input logic [7:0] b,
                                           input logic [7:0] p, input logic [7:0] v);
    logic [TOT-1:0] sh;
    if (int'(b) >= NB || int'(p) >= BW) return 8'h45;
    if (c == 8'h30) begin
      sh = gpio_in >> (int'(b) * BW + int'(p));
      return sh[0] ? 8'h31 : 8'h30;
    end
    if (c == 8'h31) mo[b[1:0]][p[2:0]] = v[0];
    else            moe[b[1:0]][p[2:0]] = v[0];
    return 8'h4B;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a byte after the current edge; it is sampled on the next edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic accept(input string tag);
    tx_ready = 1'b1;
    idle(1);
    tx_ready = 1'b0;
    chk({tag, " tx_valid after accept"}, tx_valid, 0);
    chk({tag, " state after accept"}, state_dbg, 0);
  endtask

  task automatic do_cmd(input logic [7:0] c, input logic [7:0] b, input logic [7:0] p,
                        input logic [7:0] v, input int gap, input string tag);
    logic [TOT-1:0] po;
    logic [TOT-1:0] poe;
    logic [7:0]     exp;
    po  = flat(0);
    poe = flat(1);
    send_byte(c);
    send_byte(b);
    idle(gap);
    send_byte(p);
    if (c != 8'h30) send_byte(v);
    exp = model_cmd(c, b, p, v);
    chk({tag, " tx_valid N+1"}, tx_valid, 0);
    chk({tag, " gpio_out N+1"}, gpio_out, po);
    chk({tag, " gpio_oe N+1"}, gpio_oe, poe);
    idle(1);
    chk({tag, " tx_valid N+2"}, tx_valid, 1);
    chk({tag, " tx_data"}, tx_data, exp);
    chk({tag, " gpio_out"}, gpio_out, flat(0));
    chk({tag, " gpio_oe"}, gpio_oe, flat(1));
    chk({tag, " state RESP"}, state_dbg, 5);
    idle($urandom_range(0, 3));
    chk({tag, " tx_valid held"}, tx_valid, 1);
    accept(tag);
  endtask

  initial begin
    logic [7:0] c, b, p, v;
    logic [TOT-1:0] po;
    model_reset();
    idle(3);
    chk("reset tx_valid", tx_valid, 0);
    chk("reset tx_data", tx_data, 0);
    chk("reset gpio_out", gpio_out, 0);
    chk("reset gpio_oe", gpio_oe, 0);
    chk("reset state", state_dbg, 0);
    nRst = 1'b1;
    idle(2);

    // Write bank 1 pin 3 -> bit 11
    do_cmd(8'h31, 8'h01, 8'h03, 8'h01, 0, "t1");
    chk("t1 gpio_out[11]", gpio_out[11], 1);
    idle(5);
    chk("t1 single reply", tx_valid, 0);

    // Read gpio_in[5] high then low
    gpio_in = TOT'(32'h20);
    idle(3);
    do_cmd(8'h30, 8'h00, 8'h05, 8'h00, 0, "t2a");
    chk("t2a reply literal", tx_data, 8'h31);
    gpio_in = '0;
    idle(3);
    do_cmd(8'h30, 8'h00, 8'h05, 8'h00, 0, "t2b");
    chk("t2b reply literal", tx_data, 8'h30);

    // Out-of-range bank and pin
    do_cmd(8'h32, 8'h04, 8'h00, 8'h01, 0, "t3bank");
    chk("t3 reply literal", tx_data, 8'h45);
    chk("t3 gpio_oe", gpio_oe, 0);
    do_cmd(8'h31, 8'h00, 8'h08, 8'h01, 0, "t3pin");
    do_cmd(8'h31, 8'hFF, 8'hFF, 8'h01, 0, "t3ff");

    // Hold reply for 50 cycles while injecting bytes
    send_byte(8'h31); send_byte(8'h02); send_byte(8'h07); send_byte(8'h01);
    void'(model_cmd(8'h31, 8'h02, 8'h07, 8'h01));
    idle(1);
    for (int i = 0; i < 50; i++) begin
      if (i == 10)      send_byte(8'h30);
      else if (i == 20) send_byte(8'h00);
      else if (i == 30) send_byte(8'h00);
      else              idle(1);
      chk("t4 tx_valid stable", tx_valid, 1);
      chk("t4 tx_data stable", tx_data, 8'h4B);
    end
    chk("t4 state", state_dbg, 5);
    accept("t4");
    idle(3);
    chk("t4 dropped bytes no reply", tx_valid, 0);
    chk("t4 gpio_out", gpio_out, flat(0));
    do_cmd(8'h30, 8'h02, 8'h07, 8'h00, 0, "t4next");

    // Non-command byte ignored, then read
    send_byte(8'h41);
    idle(2);
    chk("t5 ignore state", state_dbg, 0);
    chk("t5 ignore tx", tx_valid, 0);
    do_cmd(8'h30, 8'h00, 8'h00, 8'h00, 0, "t5read");

    // Reset mid-command
    do_cmd(8'h32, 8'h03, 8'h01, 8'h01, 0, "t5pre");
    send_byte(8'h31);
    send_byte(8'h00);
    nRst = 1'b0;
    #1;
    chk("t5 rst gpio_out", gpio_out, 0);
    chk("t5 rst gpio_oe", gpio_oe, 0);
    chk("t5 rst tx_valid", tx_valid, 0);
    chk("t5 rst tx_data", tx_data, 0);
    chk("t5 rst state", state_dbg, 0);
    model_reset();
    idle(2);
    nRst = 1'b1;
    idle(1);
    do_cmd(8'h31, 8'h00, 8'h01, 8'h01, 0, "t5post");

    // Reset while a reply is pending
    send_byte(8'h32); send_byte(8'h01); send_byte(8'h01); send_byte(8'h01);
    idle(1);
    chk("t5 pending", tx_valid, 1);
    nRst = 1'b0;
    #1;
    chk("t5 rst resp tx_valid", tx_valid, 0);
    chk("t5 rst resp gpio_out", gpio_out, 0);
    model_reset();
    idle(2);
    nRst = 1'b1;
    idle(1);

    // Inter-byte gap of 100 cycles
`ifdef UART_GPIO_TIMEOUT_EN
    po = flat(0);
    send_byte(8'h31);
    send_byte(8'h00);
    idle(100);
    send_byte(8'h02);
    send_byte(8'h01);
    idle(4);
    chk("t6 no reply", tx_valid, 0);
    chk("t6 gpio_out", gpio_out, po);
    chk("t6 state", state_dbg, 0);
`else
    do_cmd(8'h31, 8'h00, 8'h02, 8'h01, 100, "t6");
    chk("t6 reply literal", tx_data, 8'h4B);
    chk("t6 gpio_out[2]", gpio_out[2], 1);
`endif

    // Randomised commands against the model
    for (int n = 0; n < 40; n++) begin
      gpio_in = TOT'($urandom);
      idle(3);
      c = 8'(8'h30 + $urandom_range(0, 2));
      b = 8'($urandom_range(0, 5));
      p = 8'($urandom_range(0, 9));
      v = 8'($urandom);
      do_cmd(c, b, p, v, $urandom_range(0, 3), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
